// File: rtl/time_scale_ctrl.sv
// Speed-level controller: sole driver of the time-scale counter pulses.
// Arbitrates player config buttons and round-outcome streaks with cooldown.
module time_scale_ctrl #(
  parameter int WIN_STREAK  = 3,
  parameter int LOSS_STREAK = 2,
  parameter int MAX_LEVEL   = 9,
  parameter int GAP         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_up,
  input  logic       cfg_down,
  input  logic       game_active,
  input  logic       round_win,
  input  logic       round_lose,
  output logic       increment,
  output logic       decrement,
  output logic [3:0] level,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PLAY, PULSE, COOL} state_t;

  localparam int WW = $clog2(WIN_STREAK + 1);
  localparam int LW = $clog2(LOSS_STREAK + 1);
  localparam int CW = $clog2(GAP + 1);
  localparam logic [WW-1:0] W_LAST = WW'(WIN_STREAK - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOSS_STREAK - 1);
  localparam logic [CW-1:0] C_INIT = CW'(GAP);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [3:0]    L_MAX  = 4'(MAX_LEVEL);

  state_t state, state_d;
  logic [CW-1:0] cool, cool_d;
  logic [WW-1:0] win_cnt, win_d;
  logic [LW-1:0] loss_cnt, loss_d;
  logic pend, pend_d, pend_up, pend_up_d;
  logic go_up, go_dn;
  logic inc_d, dec_d, busy_d;
  logic [3:0] level_d;
  logic win, lose, count_en;
  logic trig_up, trig_dn, can_up, can_dn;

  assign win      = round_win & ~round_lose;
  assign lose     = round_lose & ~round_win;
  assign can_up   = level != L_MAX;
  assign can_dn   = level != 4'd0;
  assign count_en = (state == PLAY && game_active) ||
                    state == PULSE || state == COOL;
  assign trig_up  = count_en & win & (win_cnt == W_LAST);
  assign trig_dn  = count_en & lose & (loss_cnt == L_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cool      <= '0;
      win_cnt   <= '0;
      loss_cnt  <= '0;
      pend      <= 1'b0;
      pend_up   <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;
      level     <= 4'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cool      <= cool_d;
      win_cnt   <= win_d;
      loss_cnt  <= loss_d;
      pend      <= pend_d;
      pend_up   <= pend_up_d;
      increment <= inc_d;
      decrement <= dec_d;
      level     <= level_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    cool_d    = cool;
    win_d     = win_cnt;
    loss_d    = loss_cnt;
    pend_d    = pend;
    pend_up_d = pend_up;
    go_up     = 1'b0;
    go_dn     = 1'b0;
    if (count_en) begin
      if (win) begin
        win_d  = trig_up ? '0 : win_cnt + 1'b1;
        loss_d = '0;
      end else if (lose) begin
        loss_d = trig_dn ? '0 : loss_cnt + 1'b1;
        win_d  = '0;
      end
    end
    case (state)
      IDLE: begin
        if (game_active) begin
          state_d = PLAY;
        end else begin
          go_up = cfg_up & ~cfg_down & can_up;
          go_dn = cfg_down & ~cfg_up & can_dn;
        end
      end
      PLAY: begin
        if (!game_active) begin
          state_d = IDLE;
          win_d   = '0;
          loss_d  = '0;
        end else begin
          go_up = trig_up & can_up;
          go_dn = trig_dn & can_dn;
        end
      end
      PULSE, COOL: begin
        // single-entry pending slot; opposite trigger cancels
        if (trig_up | trig_dn) begin
          if (!pend) begin
            pend_d    = 1'b1;
            pend_up_d = trig_up;
          end else if (pend_up != trig_up) begin
            pend_d = 1'b0;
          end
        end
        if (state == PULSE) begin
          state_d = COOL;
          cool_d  = C_INIT;
        end else if (cool != C_ONE) begin
          cool_d = cool - 1'b1;
        end else begin
          go_up  = pend_d & pend_up_d & can_up;
          go_dn  = pend_d & ~pend_up_d & can_dn;
          pend_d = 1'b0;
          if (!(go_up | go_dn)) begin
            state_d = game_active ? PLAY : IDLE;
            if (!game_active) begin
              win_d  = '0;
              loss_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_up | go_dn) state_d = PULSE;
  end

  always_comb begin
    inc_d   = go_up;
    dec_d   = go_dn;
    busy_d  = (state_d == PULSE) || (state_d == COOL);
    level_d = level;
    if (go_up)      level_d = level + 4'd1;
    else if (go_dn) level_d = level - 4'd1;
  end

endmodule

// File: tb/tb_time_scale_ctrl.sv
// Randomized bench for time_scale_ctrl with a busy-countdown reference
// model feeding a scoreboard queue checked by an independent monitor.
module tb_time_scale_ctrl;

  localparam int WIN  = 3;
  localparam int LOSS = 2;
  localparam int MAXL = 9;
  localparam int GAP  = 2;

  logic clk = 0;
  logic rst = 0;
  logic cfg_up = 0, cfg_down = 0, game_active = 0;
  logic round_win = 0, round_lose = 0;
  logic increment, decrement, busy;
  logic [3:0] level;

  time_scale_ctrl #(
    .WIN_STREAK(WIN), .LOSS_STREAK(LOSS),
    .MAX_LEVEL(MAXL), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_up(cfg_up), .cfg_down(cfg_down),
    .game_active(game_active),
    .round_win(round_win), .round_lose(round_lose),
    .increment(increment), .decrement(decrement),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [6:0] q[$];

  int m_lvl = 0, m_bl = 0, m_w = 0, m_l = 0;
  bit m_play = 0, m_pv = 0, m_pup = 0;
  bit e_inc, e_dec;

  task automatic streak(input bit w, input bit l,
                        output bit tu, output bit td);
    tu = 0;
    td = 0;
    if (w && !l) begin
      m_w++;
      m_l = 0;
      if (m_w == WIN) begin m_w = 0; tu = 1; end
    end else if (l && !w) begin
      m_l++;
      m_w = 0;
      if (m_l == LOSS) begin m_l = 0; td = 1; end
    end
  endtask

  task automatic issue(input bit u, input bit d);
    if (u && m_lvl < MAXL) begin
      m_lvl++; e_inc = 1; m_bl = GAP + 1;
    end else if (d && m_lvl > 0) begin
      m_lvl--; e_dec = 1; m_bl = GAP + 1;
    end
  endtask

  task automatic model(input bit r, input bit u, input bit d,
                       input bit g, input bit w, input bit l);
    bit tu, td;
    e_inc = 0;
    e_dec = 0;
    tu = 0;
    td = 0;
    if (!r) begin
      m_lvl = 0; m_bl = 0; m_w = 0; m_l = 0;
      m_play = 0; m_pv = 0; m_pup = 0;
    end else if (m_bl == 0) begin
      if (!m_play) begin
        if (g) m_play = 1;
        else begin tu = u && !d; td = d && !u; end
      end else if (!g) begin
        m_play = 0; m_w = 0; m_l = 0;
      end else begin
        streak(w, l, tu, td);
      end
      issue(tu, td);
    end else begin
      streak(w, l, tu, td);
      if (tu || td) begin
        if (!m_pv) begin m_pv = 1; m_pup = tu; end
        else if (m_pup != tu) m_pv = 0;
      end
      m_bl--;
      if (m_bl == 0) begin
        issue(m_pv && m_pup, m_pv && !m_pup);
        m_pv = 0;
        if (m_bl == 0) begin
          m_play = g;
          if (!g) begin m_w = 0; m_l = 0; end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit u, input bit d,
                     input bit g, input bit w, input bit l);
    @(negedge clk);
    rst = r; cfg_up = u; cfg_down = d;
    game_active = g; round_win = w; round_lose = l;
    model(r, u, d, g, w, l);
    q.push_back({e_inc, e_dec, 4'(m_lvl), m_bl != 0});
  endtask

  task automatic idle(input int n, input bit g);
    repeat (n) cyc(1, 0, 0, g, 0, 0);
  endtask

  initial begin : monitor
    logic [6:0] exp, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp = q.pop_front();
        got = {increment, decrement, level, busy};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t got inc=%b dec=%b lvl=%0d busy=%b want inc=%b dec=%b lvl=%0d busy=%b",
                   $time, got[6], got[5], got[4:1], got[0],
                   exp[6], exp[5], exp[4:1], exp[0]);
        end
      end
    end
  end

  initial begin : stim
    bit g;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++)
      cyc(1, i == 5 || i == 12 || i == 19, 0, 0, 0, 0);
    repeat (8) begin cyc(1, 1, 0, 0, 0, 0); idle(4, 0); end
    cyc(1, 1, 0, 0, 0, 0);
    idle(4, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    idle(4, 0);
    cyc(1, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 1, 0); idle(2, 1);
    end
    idle(4, 1);
    cyc(1, 0, 0, 1, 0, 1); idle(1, 1);
    cyc(1, 0, 0, 1, 1, 0); idle(1, 1);
    cyc(1, 0, 0, 1, 0, 1); idle(1, 1);
    cyc(1, 0, 0, 1, 0, 1); idle(5, 1);
    idle(2, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(4, 0);
    cyc(1, 1, 1, 0, 0, 0);
    idle(3, 0);
    repeat (3) cyc(1, 0, 0, 1, 1, 0);
    repeat (3) cyc(1, 0, 0, 1, 1, 0);
    idle(6, 1);
    repeat (3) cyc(1, 0, 0, 1, 1, 0);
    idle(2, 1);
    cyc(0, 0, 0, 1, 0, 0);
    idle(3, 0);
    g = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) g = ~g;
      cyc($urandom_range(0, 299) != 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
          g, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_scale_ctrl.md
Name: time_scale_ctrl

Overview:
Controller that owns the game's speed-level setting and is the only driver of the time-scaling counter's increment/decrement pulse inputs. It arbitrates between player configuration buttons (between rounds) and automatic difficulty adjustment from round outcomes (during play). It issues rate-limited single-cycle pulses and keeps a shadow copy of the level so it never issues a pulse the counter would ignore at its saturation limits.

Parameters:
WIN_STREAK, 3, consecutive round wins that trigger one level-up
LOSS_STREAK, 2, consecutive round losses that trigger one level-down
MAX_LEVEL, 9, upper saturation value of the level (lower is 0)
GAP, 2, minimum idle cycles after each issued pulse before the next one (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
cfg_up  input  1  one-cycle pulse, debounced player "faster" button
cfg_down  input  1  one-cycle pulse, debounced player "slower" button
game_active  input  1  high while a round sequence is in progress
round_win  input  1  one-cycle pulse at the end of a won round
round_lose  input  1  one-cycle pulse at the end of a lost round
increment  output  1  one-cycle pulse to the time-scaling counter
decrement  output  1  one-cycle pulse to the time-scaling counter
level  output  4  shadow of the counter value, 0..MAX_LEVEL
busy  output  1  high while a pulse or cooldown is in progress

Behaviour:
- Reset (rst=0 at posedge): increment=0, decrement=0, level=0, busy=0, win_cnt=0, loss_cnt=0, pending cleared, state IDLE. Applies in every state, including mid-PULSE/COOL.
- All outputs registered. States: IDLE, PLAY, PULSE, COOL.
- IDLE: busy=0. game_active=1 -> PLAY. Else cfg_up alone -> PULSE(up); cfg_down alone -> PULSE(down); both in the same cycle -> ignored. win_cnt/loss_cnt held at 0.
- PLAY: cfg_up/cfg_down ignored. round_win: win_cnt+1, loss_cnt=0. round_lose: loss_cnt+1, win_cnt=0. Both in the same cycle -> ignored, counters unchanged. win_cnt reaching WIN_STREAK -> win_cnt=0, request up; loss_cnt reaching LOSS_STREAK -> loss_cnt=0, request down. Request with no pulse in progress -> PULSE on the same edge. game_active=0 -> IDLE, counters cleared.
- Latency: a request sampled at edge t drives increment/decrement high for exactly the cycle after t. level updates on the same edge (+1 or -1). busy rises on the same edge.
- PULSE: lasts one cycle, then COOL with a cooldown counter of GAP. increment and decrement are never high together.
- COOL: busy=1 and both pulse outputs 0 for GAP cycles. cfg_up/cfg_down arriving during PULSE/COOL are dropped, not queued. Round outcomes during PULSE/COOL still update the streak counters. A streak trigger sets a single-entry pending flag with direction. An opposite-direction trigger clears an existing pending flag (cancel). A same-direction trigger has no further effect. After the cooldown expires: pending present -> PULSE (pending cleared). Else game_active=1 -> PLAY, game_active=0 -> IDLE with counters and pending cleared.
- Saturation: an up request at level==MAX_LEVEL or a down request at level==0 is dropped. No pulse, state unchanged, the triggering streak counter is still cleared.
- level never leaves 0..MAX_LEVEL. It tracks the counter exactly, given both blocks are reset together.

Test Plan:
- Reset, idle, cfg_up pulses at cycles 5, 12 and 19 -> increment high for one cycle each at 6, 13 and 20. level 1, 2, 3. busy high cycles 6-8 (GAP=2).
- level=9, then cfg_up -> no increment, level 9, busy 0. Reset, then cfg_down -> no decrement, level 0.
- game_active=1, cfg_up -> ignored. round_win x3, third at cycle t -> increment at t+1 only, level +1, win_cnt=0. Earlier wins produce no pulse.
- PLAY sequence lose, win, lose, lose -> exactly one decrement, one cycle after the final lose. Level drops by 1.
- cfg_up at cycles 5 and 6 -> one increment at 6, second request dropped. cfg_up and cfg_down together -> no pulse.
- Third win arrives during COOL -> increment issued on the first cycle after the cooldown. Assert rst=0 during COOL -> next edge all outputs 0 and level 0.
